// File: rtl/stats_readout_pkg.sv
// Shared definitions for the statistics snapshot/readout block:
// register indices, status bit positions and FSM state encoding.
package stats_readout_pkg;

  localparam logic [2:0] REG_DATA_CTR  = 3'd0;
  localparam logic [2:0] REG_ERROR_CTR = 3'd1;
  localparam logic [2:0] REG_MAXACC    = 3'd2;
  localparam logic [2:0] REG_MINACC    = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;

  localparam int unsigned ST_BUSY_BIT    = 18;
  localparam int unsigned ST_OVERRUN_BIT = 17;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/stats_readout_if.sv
// Host/scoreboard-facing signal bundle of stats_readout.
// master: the host + scoreboard side; slave: the readout block.
interface stats_readout_if;

  logic        i_snap_req;
  logic        o_freeze;
  logic [31:0] i_data_ctr;
  logic [31:0] i_error_ctr;
  logic [31:0] i_maxacc;
  logic [31:0] i_minacc;
  logic        i_read;
  logic [2:0]  i_addr;
  logic [31:0] o_readdata;
  logic        o_readdatavalid;
  logic        o_snap_busy;
  logic        o_snap_done;

  modport master (
    output i_snap_req, i_data_ctr, i_error_ctr, i_maxacc, i_minacc,
           i_read, i_addr,
    input  o_freeze, o_readdata, o_readdatavalid, o_snap_busy, o_snap_done
  );

  modport slave (
    input  i_snap_req, i_data_ctr, i_error_ctr, i_maxacc, i_minacc,
           i_read, i_addr,
    output o_freeze, o_readdata, o_readdatavalid, o_snap_busy, o_snap_done
  );

endinterface

// File: rtl/stats_readout.sv
// Statistics snapshot and register readout.
// A snapshot request freezes the scoreboard, waits SETTLE cycles for
// in-flight updates to retire, captures the four live statistics and
// pulses done. Host reads are served every cycle with one-cycle latency.
module stats_readout
  import stats_readout_pkg::*;
#(
  parameter int unsigned SETTLE = 2,   // legal 1..15
  parameter int unsigned SNAP_W = 16   // snap_count width, legal 1..16
) (
  input  logic           clk,
  input  logic           reset,
  stats_readout_if.slave bus
);

  state_t            state, state_nxt;
  logic [3:0]        settle_cnt, settle_nxt;
  logic [31:0]       snap_data, snap_error, snap_max, snap_min;
  logic [SNAP_W-1:0] snap_count;
  logic              overrun;
  logic              overrun_set;
  logic              status_rd;
  logic              busy;
  logic [31:0]       rd_mux;

  // Requests outside IDLE (DONE included) are dropped and flagged.
  assign overrun_set = bus.i_snap_req && (state != S_IDLE);
  assign status_rd   = bus.i_read && (bus.i_addr == REG_STATUS);

  // State register and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next-state logic; DRAIN lasts exactly SETTLE cycles.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      S_IDLE: begin
        if (bus.i_snap_req) begin
          state_nxt  = S_DRAIN;
          settle_nxt = 4'(SETTLE - 1);
        end
      end
      S_DRAIN: begin
        if (settle_cnt == '0) state_nxt = S_CAPTURE;
        else                  settle_nxt = settle_cnt - 4'd1;
      end
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops freeze asynchronously.
  always_comb begin
    busy            = 1'b0;
    bus.o_snap_done = 1'b0;
    case (state)
      S_DRAIN, S_CAPTURE: busy = 1'b1;
      S_DONE:             bus.o_snap_done = 1'b1;
      default:            ;
    endcase
    bus.o_freeze    = busy;
    bus.o_snap_busy = busy;
  end

  // Snapshot capture and snapshot counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_data  <= '0;
      snap_error <= '0;
      snap_max   <= '0;
      snap_min   <= '0;
      snap_count <= '0;
    end else if (state == S_CAPTURE) begin
      snap_data  <= bus.i_data_ctr;
      snap_error <= bus.i_error_ctr;
      snap_max   <= bus.i_maxacc;
      snap_min   <= bus.i_minacc;
      snap_count <= snap_count + SNAP_W'(1);
    end
  end

  // Sticky overrun; a set in the same cycle as a status read wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (overrun_set) overrun <= 1'b1;
    else if (status_rd)   overrun <= 1'b0;
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = '0;
    case (bus.i_addr)
      REG_DATA_CTR:  rd_mux = snap_data;
      REG_ERROR_CTR: rd_mux = snap_error;
      REG_MAXACC:    rd_mux = snap_max;
      REG_MINACC:    rd_mux = snap_min;
      REG_STATUS: begin
        rd_mux[15:0]           = 16'(snap_count);
        rd_mux[ST_OVERRUN_BIT] = overrun | overrun_set;
        rd_mux[ST_BUSY_BIT]    = busy;
      end
      default:       rd_mux = '0;
    endcase
  end

  // Registered read response, zero when not valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.o_readdata      <= '0;
      bus.o_readdatavalid <= 1'b0;
    end else begin
      bus.o_readdatavalid <= bus.i_read;
      bus.o_readdata      <= bus.i_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_stats_readout.sv
// Directed self-checking bench for stats_readout.
// Main instance uses SETTLE=2; a second instance with a 4-bit snapshot
// counter exercises counter wrap in a practical number of cycles.
module tb_stats_readout;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stats_readout_if bus ();
  stats_readout_if bus2 ();

  stats_readout #(.SETTLE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  stats_readout #(.SETTLE(1), .SNAP_W(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus.i_read = 1'b1;
    bus.i_addr = a;
    tick();
    bus.i_read = 1'b0;
    chk({tag, "_valid"}, 32'(bus.o_readdatavalid), 32'd1);
    chk(tag, bus.o_readdata, exp);
  endtask

  task automatic rd2(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus2.i_read = 1'b1;
    bus2.i_addr = a;
    tick();
    bus2.i_read = 1'b0;
    chk({tag, "_valid"}, 32'(bus2.o_readdatavalid), 32'd1);
    chk(tag, bus2.o_readdata, exp);
  endtask

  task automatic snap2(input string tag);
    int n;
    bus2.i_snap_req = 1'b1;
    tick();
    bus2.i_snap_req = 1'b0;
    n = 0;
    while (!bus2.o_snap_done && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus2.o_snap_done), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.i_snap_req  = 1'b0; bus.i_read  = 1'b0; bus.i_addr  = '0;
    bus.i_data_ctr  = '0;   bus.i_error_ctr = '0;
    bus.i_maxacc    = '0;   bus.i_minacc    = '0;
    bus2.i_snap_req = 1'b0; bus2.i_read = 1'b0; bus2.i_addr = '0;
    bus2.i_data_ctr = 32'h11; bus2.i_error_ctr = 32'h22;
    bus2.i_maxacc   = 32'h33; bus2.i_minacc    = 32'h44;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_freeze", 32'(bus.o_freeze), 32'd0);
    chk("rst_busy",   32'(bus.o_snap_busy), 32'd0);
    chk("rst_done",   32'(bus.o_snap_done), 32'd0);
    chk("rst_valid",  32'(bus.o_readdatavalid), 32'd0);
    chk("rst_data",   bus.o_readdata, 32'd0);
    reset = 1'b0;
    tick();

    // Snapshot 1: timing, capture values, pre-capture read in CAPTURE
    bus.i_data_ctr  = 32'd100;
    bus.i_error_ctr = 32'd3;
    bus.i_maxacc    = 32'hDEAD_BEEF;
    bus.i_minacc    = 32'd7;
    bus.i_snap_req  = 1'b1;
    tick();                                   // T+1 DRAIN
    bus.i_snap_req = 1'b0;
    chk("s1_freeze_t1", 32'(bus.o_freeze), 32'd1);
    chk("s1_busy_t1",   32'(bus.o_snap_busy), 32'd1);
    chk("s1_done_t1",   32'(bus.o_snap_done), 32'd0);
    tick();                                   // T+2 DRAIN
    chk("s1_freeze_t2", 32'(bus.o_freeze), 32'd1);
    tick();                                   // T+3 CAPTURE
    chk("s1_freeze_t3", 32'(bus.o_freeze), 32'd1);
    chk("s1_done_t3",   32'(bus.o_snap_done), 32'd0);
    bus.i_read = 1'b1;
    bus.i_addr = 3'd0;
    tick();                                   // T+4 DONE
    bus.i_read = 1'b0;
    chk("s1_precap_valid", 32'(bus.o_readdatavalid), 32'd1);
    chk("s1_precap_data",  bus.o_readdata, 32'd0);
    chk("s1_freeze_t4", 32'(bus.o_freeze), 32'd0);
    chk("s1_busy_t4",   32'(bus.o_snap_busy), 32'd0);
    chk("s1_done_t4",   32'(bus.o_snap_done), 32'd1);
    bus.i_data_ctr  = 32'd200;
    bus.i_error_ctr = 32'd9;
    bus.i_maxacc    = 32'h1234_5678;
    bus.i_minacc    = 32'd1;
    tick();                                   // T+5 IDLE
    chk("s1_done_t5",  32'(bus.o_snap_done), 32'd0);
    chk("idle_valid",  32'(bus.o_readdatavalid), 32'd0);
    chk("idle_data",   bus.o_readdata, 32'd0);
    rd(3'd0, 32'd100,         "rd_data_ctr");
    rd(3'd1, 32'd3,           "rd_error_ctr");
    rd(3'd2, 32'hDEAD_BEEF,   "rd_maxacc");
    rd(3'd3, 32'd7,           "rd_minacc");
    rd(3'd4, 32'h0000_0001,   "rd_status1");
    tick();
    chk("valid_drop", 32'(bus.o_readdatavalid), 32'd0);

    // Snapshot 2: second request during DRAIN is dropped
    bus.i_snap_req = 1'b1;
    tick();                                   // DRAIN
    tick();                                   // request held: overrun
    bus.i_snap_req = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.o_snap_done) dones++;
      tick();
    end
    chk("s2_done_count", 32'(dones), 32'd1);
    chk("s2_idle_freeze", 32'(bus.o_freeze), 32'd0);
    rd(3'd4, 32'h0002_0002, "s2_status_ovr");
    rd(3'd4, 32'h0000_0002, "s2_status_clr");

    // Snapshot 3: overrun set with status read in same cycle, DONE drop
    bus.i_snap_req = 1'b1;
    tick();                                   // DRAIN 1
    bus.i_snap_req = 1'b1;
    bus.i_read = 1'b1;
    bus.i_addr = 3'd4;
    tick();                                   // DRAIN 2
    bus.i_snap_req = 1'b0;
    chk("s3_same_cycle", bus.o_readdata, 32'h0006_0002);
    tick();                                   // CAPTURE
    bus.i_read = 1'b0;
    chk("s3_ovr_kept", bus.o_readdata, 32'h0006_0002);
    tick();                                   // DONE
    chk("s3_done", 32'(bus.o_snap_done), 32'd1);
    bus.i_snap_req = 1'b1;
    tick();                                   // IDLE, request dropped
    bus.i_snap_req = 1'b0;
    chk("s3_drop_freeze_a", 32'(bus.o_freeze), 32'd0);
    tick();
    chk("s3_drop_freeze_b", 32'(bus.o_freeze), 32'd0);
    rd(3'd4, 32'h0002_0003, "s3_status_ovr");
    rd(3'd4, 32'h0000_0003, "s3_status_clr");

    // Unmapped addresses
    rd(3'd5, 32'd0, "rd_addr5");
    rd(3'd6, 32'd0, "rd_addr6");
    rd(3'd7, 32'd0, "rd_addr7");

    // Reset during DRAIN aborts the snapshot
    bus.i_snap_req = 1'b1;
    tick();
    bus.i_snap_req = 1'b0;
    chk("r_freeze_pre", 32'(bus.o_freeze), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("r_freeze_async", 32'(bus.o_freeze), 32'd0);
    chk("r_busy_async",   32'(bus.o_snap_busy), 32'd0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_snap_done) dones++;
      tick();
    end
    chk("r_no_done", 32'(dones), 32'd0);
    rd(3'd4, 32'd0, "r_status");
    rd(3'd0, 32'd0, "r_snap_data");

    // Counter wrap on the narrow-counter instance
    for (int i = 0; i < 15; i++) snap2("w_done");
    rd2(3'd4, 32'h0000_000F, "w_status_max");
    snap2("w_done_wrap");
    rd2(3'd4, 32'h0000_0000, "w_status_wrap");
    rd2(3'd0, 32'h0000_0011, "w_snap_data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stats_readout.md
STATS_READOUT -- requirements
Module: stats_readout

Interface
REQ-001 Parameter: SETTLE, default 2, freeze cycles before capture so in-flight scoreboard updates retire (legal 1..15).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_snap_req  in  1  host snapshot request, one-cycle pulse.
REQ-005 o_freeze  out  1  freeze to scoreboard; high from request accept through capture.
REQ-006 i_data_ctr, i_error_ctr, i_maxacc, i_minacc  in  32 each  live scoreboard statistics.
REQ-007 i_read  in  1  host read strobe; i_addr  in  3  register index.
REQ-008 o_readdata  out  32  read data; o_readdatavalid  out  1  read data qualifier.
REQ-009 o_snap_busy  out  1  high while snapshot in progress; o_snap_done  out  1  one-cycle pulse on completion.

Function
REQ-010 FSM states IDLE, DRAIN, CAPTURE, DONE; reset state IDLE.
REQ-011 IDLE + i_snap_req: next cycle state DRAIN, o_freeze=1, o_snap_busy=1, settle counter loaded SETTLE-1.
REQ-012 DRAIN: counter decrements each cycle; at 0 next state CAPTURE (DRAIN lasts exactly SETTLE cycles).
REQ-013 CAPTURE (1 cycle): latch all four inputs into snapshot registers; snap_count (16 bit) increments, wraps 0xFFFF->0x0000; next state DONE.
REQ-014 DONE (1 cycle): o_freeze=0, o_snap_busy=0, o_snap_done=1; next state IDLE.
REQ-015 o_freeze high in DRAIN and CAPTURE only; request-to-capture latency SETTLE+1 cycles; request-to-done SETTLE+2.
REQ-016 i_snap_req outside IDLE is dropped and sets sticky overrun bit; request in the same cycle as DONE is also dropped.
REQ-017 Address map: 0 data_ctr, 1 error_ctr, 2 maxacc, 3 minacc (snapshot copies), 4 status = {13'b0, busy[18], overrun[17], 1'b0[16], snap_count[15:0]}, 5..7 read 0.
REQ-018 Read latency 1: o_readdatavalid high the cycle after i_read, o_readdata valid that cycle, else o_readdata=0.
REQ-019 Read of status clears overrun; overrun set and status read in same cycle -> overrun remains 1 and read returns 1.
REQ-020 Read sampled in CAPTURE cycle returns pre-capture snapshot value.
REQ-021 Reads accepted every cycle, any state; reads never affect FSM.

Reset
REQ-022 Reset: state IDLE; o_freeze, o_snap_busy, o_snap_done, o_readdatavalid, overrun = 0; o_readdata, snapshots, snap_count = 0.
REQ-023 Reset asserted mid-snapshot aborts immediately; o_freeze drops asynchronously; no capture, no done pulse.

Structure
REQ-024 Shared package holds register index constants (0..4), status bit positions, FSM state encoding.
REQ-025 Single module; no sub-modules required.

Verification
REQ-026 SETTLE=2, pulse i_snap_req at T -> o_freeze 1 at T+1..T+3, capture at T+3, o_snap_done at T+4, status snap_count=1.
REQ-027 Inputs data_ctr=100, error_ctr=3 during capture, then change to 200/9 -> reads of addr 0/1 return 100/3, valid 1 cycle after i_read.
REQ-028 Second i_snap_req during DRAIN -> ignored, single done pulse, status read shows overrun=1, next status read overrun=0.
REQ-029 snap_count preloaded to 0xFFFF via 65535 snapshots -> next snapshot reads snap_count=0x0000.
REQ-030 Reset asserted in DRAIN -> o_freeze 0 immediately, no o_snap_done, snapshots and snap_count remain 0.
REQ-031 Read addr 5, 6, 7 -> o_readdata=0 with o_readdatavalid=1.
